req_pkt_checker: RTL and testbench
==================================

REQ_PKT_CHECKER -- requirements
Module: req_pkt_checker

Interface
REQ-001 Parameter DATA_MAX, default 16'd1024, is the largest legal data word count per packet.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 check_en  input  1  enables checking; low forces IDLE and holds all counters.
REQ-005 err_clr  input  1  one-cycle pulse; clears all captured errors and err_cnt.
REQ-006 evt_start  input  64  first expected event tag, loaded while check_en is low.
REQ-007 hdr1_ref, hdr2_ref  input  64 each  expected header words.
REQ-008 data_len  input  16  data words per packet (N); sampled when the event word is accepted.
REQ-009 data_in  input  64  stream word; data_valid input 1 qualifies it; data_last input 1 marks the final word.
REQ-010 evt_expc/evt_seen, hdr1_expc/hdr1_seen, hdr2_expc/hdr2_seen, data_expc/data_seen  output  64 each  first mismatch captured per category.
REQ-011 err_en  output  2  category of first error since clear: 00 evt, 01 hdr1, 10 hdr2, 11 data.
REQ-012 err_flag  output  1  sticky, high once any error is captured.
REQ-013 err_cnt  output  16  total mismatching words, saturating at 16'hFFFF.
REQ-014 pkt_cnt  output  32  completed packets, wraps at 2^32.

Function
REQ-015 FSM states: IDLE, EVT, HDR1, HDR2, DATA; states advance only on cycles with data_valid high.
REQ-016 IDLE: while check_en low, exp_evt <= evt_start; check_en high -> EVT on the next cycle.
REQ-017 EVT: compare data_in with exp_evt; -> HDR1; latch N = data_len and data index k = 0.
REQ-018 Event mismatch resync: next exp_evt = data_in + 1; on match, exp_evt + 1 (64-bit wrap).
REQ-019 HDR1: compare with hdr1_ref -> HDR2. HDR2: compare with hdr2_ref -> DATA, or -> EVT if N = 0.
REQ-020 DATA: expected word = {cur_evt[31:0], 16'h0, k}, where cur_evt is the event tag received in EVT and k counts from 0.
REQ-021 DATA: mismatch on any of the following: word differs; data_last high with k < N-1; data_last low with k = N-1.
REQ-022 Early data_last ends the packet. Packet ends at k = N-1 regardless of data_last; -> EVT; pkt_cnt increments.
REQ-023 N > DATA_MAX: treated as N = DATA_MAX.
REQ-024 Per-category capture: on the first mismatch in a category since clear, latch the {expc, seen} pair; later mismatches leave it unchanged.
REQ-025 err_en and err_flag latch on the first mismatch of any category; they are not overwritten until err_clr.
REQ-026 Every mismatching word increments err_cnt by 1; the count holds at 16'hFFFF.
REQ-027 All captures and counters register one cycle after the offending data_valid word.
REQ-028 err_clr in the same cycle as a mismatch: clear first, then capture the new mismatch (err_cnt = 1).
REQ-029 check_en falling mid-packet: -> IDLE next cycle; the partial packet is discarded without counting; captured errors are retained.
REQ-030 data_valid low cycles: state, k and comparisons hold.

Reset
REQ-031 reset_n low asynchronously forces IDLE; all outputs to 0; exp_evt, k, N to 0.
REQ-032 Reset released mid-stream: the block stays in IDLE until check_en is seen high.

Verification
REQ-033 evt_start=0x10, N=4: 3 clean packets -> pkt_cnt=3, err_flag=0, err_cnt=0, final exp_evt=0x13.
REQ-034 Packet 2 hdr1 = hdr1_ref^1 -> err_en=01, hdr1_seen=hdr1_ref^1, hdr1_expc=hdr1_ref, err_cnt=1; a later data error sets data_* but err_en stays 01.
REQ-035 Event tag 0x20 where 0x11 is expected -> evt_expc=0x11, evt_seen=0x20, err_en=00; the next packet tag 0x21 passes.
REQ-036 N=4 with data_last on k=1 -> data error (data_expc low 16 bits = 1), return to EVT, pkt_cnt+1; data_last missing at k=3 -> err_cnt+1.
REQ-037 err_clr coincident with a hdr2 mismatch -> err_flag=1, err_en=10, err_cnt=1; reset_n pulsed mid-DATA -> all outputs 0 and state IDLE.
REQ-038 Force 70000 mismatches -> err_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/req_pkt_checker_if.sv
// Stream bus carrying event/header/data words into the packet checker.
interface req_pkt_checker_if;
    logic [63:0] data_in;
    logic        data_valid;
    logic        data_last;

    modport master (output data_in, data_valid, data_last);
    modport slave  (input  data_in, data_valid, data_last);
endinterface

// File: rtl/req_pkt_checker.sv
// Checks an EVT/HDR1/HDR2/DATA packet stream against expected tags, headers and
// an incrementing data pattern; captures the first mismatch per category.
module req_pkt_checker #(
    parameter logic [15:0] DATA_MAX = 16'd1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     check_en,
    input  logic                     err_clr,
    input  logic [63:0]              evt_start,
    input  logic [63:0]              hdr1_ref,
    input  logic [63:0]              hdr2_ref,
    input  logic [15:0]              data_len,
    req_pkt_checker_if.slave         stream,
    output logic [63:0]              evt_expc,
    output logic [63:0]              evt_seen,
    output logic [63:0]              hdr1_expc,
    output logic [63:0]              hdr1_seen,
    output logic [63:0]              hdr2_expc,
    output logic [63:0]              hdr2_seen,
    output logic [63:0]              data_expc,
    output logic [63:0]              data_seen,
    output logic [1:0]               err_en,
    output logic                     err_flag,
    output logic [15:0]              err_cnt,
    output logic [31:0]              pkt_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_EVT, S_HDR1, S_HDR2, S_DATA} state_t;

    state_t           state_q, state_d;
    logic [63:0]      exp_evt_q, exp_evt_d;
    logic [31:0]      cur_evt_q, cur_evt_d;
    logic [15:0]      n_q, n_d, k_q, k_d;
    logic [31:0]      pkt_cnt_q, pkt_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [1:0]       err_en_q, err_en_d;
    logic             err_flag_q, err_flag_d;
    logic [3:0]       cap_q, cap_d;
    logic [3:0][63:0] expc_q, expc_d, seen_q, seen_d;

    logic        step, mism, pkt_done, k_last;
    logic [1:0]  cat;
    logic [63:0] cmp_exp;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        if (!check_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_EVT;
                S_EVT:   if (stream.data_valid) state_d = S_HDR1;
                S_HDR1:  if (stream.data_valid) state_d = S_HDR2;
                S_HDR2:  if (stream.data_valid) state_d = (n_q == 16'd0) ? S_EVT : S_DATA;
                S_DATA:  if (pkt_done) state_d = S_EVT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // state outputs: what the current word is compared against
    always_comb begin
        step     = check_en && stream.data_valid;
        k_last   = (k_q == n_q - 16'd1);
        cmp_exp  = '0;
        cat      = 2'd0;
        mism     = 1'b0;
        pkt_done = 1'b0;
        case (state_q)
            S_EVT: begin
                cmp_exp = exp_evt_q;
                cat     = 2'd0;
                mism    = step && (stream.data_in != cmp_exp);
            end
            S_HDR1: begin
                cmp_exp = hdr1_ref;
                cat     = 2'd1;
                mism    = step && (stream.data_in != cmp_exp);
            end
            S_HDR2: begin
                cmp_exp  = hdr2_ref;
                cat      = 2'd2;
                mism     = step && (stream.data_in != cmp_exp);
                pkt_done = step && (n_q == 16'd0);
            end
            S_DATA: begin
                cmp_exp  = {cur_evt_q, 16'h0, k_q};
                cat      = 2'd3;
                // a misplaced or missing data_last is itself a data error
                mism     = step && ((stream.data_in != cmp_exp) || (stream.data_last != k_last));
                pkt_done = step && (stream.data_last || k_last);
            end
            default: ;
        endcase
    end

    // datapath and error capture
    always_comb begin
        exp_evt_d  = exp_evt_q;
        cur_evt_d  = cur_evt_q;
        n_d        = n_q;
        k_d        = k_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_en_d   = err_en_q;
        err_flag_d = err_flag_q;
        cap_d      = cap_q;
        expc_d     = expc_q;
        seen_d     = seen_q;

        if (!check_en) begin
            exp_evt_d = evt_start;
        end else if (state_q == S_EVT && stream.data_valid) begin
            // resync on a bad tag so one dropped event costs one error
            exp_evt_d = (mism ? stream.data_in : exp_evt_q) + 64'd1;
            cur_evt_d = stream.data_in[31:0];
            n_d       = (data_len > DATA_MAX) ? DATA_MAX : data_len;
            k_d       = 16'd0;
        end

        if (state_q == S_DATA && step && !pkt_done) k_d = k_q + 16'd1;
        if (pkt_done) pkt_cnt_d = pkt_cnt_q + 32'd1;

        if (err_clr) begin
            cap_d      = '0;
            expc_d     = '0;
            seen_d     = '0;
            err_cnt_d  = '0;
            err_en_d   = '0;
            err_flag_d = 1'b0;
        end

        if (mism) begin
            if (!cap_d[cat]) begin
                cap_d[cat]  = 1'b1;
                expc_d[cat] = cmp_exp;
                seen_d[cat] = stream.data_in;
            end
            if (!err_flag_d) begin
                err_flag_d = 1'b1;
                err_en_d   = cat;
            end
            if (err_cnt_d != 16'hFFFF) err_cnt_d = err_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_evt_q  <= '0;
            cur_evt_q  <= '0;
            n_q        <= '0;
            k_q        <= '0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
            err_en_q   <= '0;
            err_flag_q <= 1'b0;
            cap_q      <= '0;
            expc_q     <= '0;
            seen_q     <= '0;
        end else begin
            exp_evt_q  <= exp_evt_d;
            cur_evt_q  <= cur_evt_d;
            n_q        <= n_d;
            k_q        <= k_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_en_q   <= err_en_d;
            err_flag_q <= err_flag_d;
            cap_q      <= cap_d;
            expc_q     <= expc_d;
            seen_q     <= seen_d;
        end
    end

    assign evt_expc  = expc_q[0];
    assign evt_seen  = seen_q[0];
    assign hdr1_expc = expc_q[1];
    assign hdr1_seen = seen_q[1];
    assign hdr2_expc = expc_q[2];
    assign hdr2_seen = seen_q[2];
    assign data_expc = expc_q[3];
    assign data_seen = seen_q[3];
    assign err_en    = err_en_q;
    assign err_flag  = err_flag_q;
    assign err_cnt   = err_cnt_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_req_pkt_checker.sv
// Packet-level bench: table of packets with expected counters, scoreboard queue,
// plus abort, reset and saturation sequences.
module tb_req_pkt_checker;

    localparam logic [15:0] DMAX = 16'd8;
    localparam logic [63:0] H1   = 64'hA5A5_0000_1111_2222;
    localparam logic [63:0] H2   = 64'h5A5A_3333_0000_4444;

    logic        clk = 1'b0, reset_n = 1'b0, check_en = 1'b0, err_clr = 1'b0;
    logic [63:0] evt_start, hdr1_ref, hdr2_ref;
    logic [15:0] data_len;
    logic [63:0] evt_expc, evt_seen, hdr1_expc, hdr1_seen;
    logic [63:0] hdr2_expc, hdr2_seen, data_expc, data_seen;
    logic [1:0]  err_en;
    logic        err_flag;
    logic [15:0] err_cnt;
    logic [31:0] pkt_cnt;

    req_pkt_checker_if sif();

    req_pkt_checker #(.DATA_MAX(DMAX)) dut (
        .clk(clk), .reset_n(reset_n), .check_en(check_en), .err_clr(err_clr),
        .evt_start(evt_start), .hdr1_ref(hdr1_ref), .hdr2_ref(hdr2_ref),
        .data_len(data_len), .stream(sif),
        .evt_expc(evt_expc), .evt_seen(evt_seen),
        .hdr1_expc(hdr1_expc), .hdr1_seen(hdr1_seen),
        .hdr2_expc(hdr2_expc), .hdr2_seen(hdr2_seen),
        .data_expc(data_expc), .data_seen(data_seen),
        .err_en(err_en), .err_flag(err_flag), .err_cnt(err_cnt), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] tag, h1x, h2x;
        int len, nwords, last_at, dbad, clr;
        int pkt, ecnt, flag, en;
    } vec_t;

    typedef struct { int pkt, ecnt, flag, en; } exp_t;

    exp_t sbq[$];
    vec_t vt[12];
    int   checks = 0, errors = 0;

    function automatic vec_t mk(input logic [63:0] tag, h1x, h2x, input int len, nw, la, db, cl,
                                input int p, e, f, en);
        vec_t v;
        v.tag = tag; v.h1x = h1x; v.h2x = h2x; v.len = len; v.nwords = nw;
        v.last_at = la; v.dbad = db; v.clr = cl;
        v.pkt = p; v.ecnt = e; v.flag = f; v.en = en;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic l, input logic c);
        sif.data_in = d; sif.data_valid = 1'b1; sif.data_last = l; err_clr = c;
        @(posedge clk); #1;
        sif.data_valid = 1'b0; sif.data_last = 1'b0; err_clr = 1'b0;
    endtask

    task automatic send_pkt(input vec_t v);
        data_len = 16'(v.len);
        send(v.tag, 1'b0, 1'b0);
        send(H1 ^ v.h1x, 1'b0, 1'b0);
        @(posedge clk); #1;  // idle gap inside the packet
        send(H2 ^ v.h2x, 1'b0, v.clr == 2);
        for (int k = 0; k < v.nwords; k++) begin
            logic [63:0] w;
            w = {v.tag[31:0], 16'h0, 16'(k)};
            if (k == v.dbad) w = w ^ 64'd1;
            send(w, k == v.last_at, 1'b0);
        end
    endtask

    task automatic push(input int p, e, f, en);
        exp_t x;
        x.pkt = p; x.ecnt = e; x.flag = f; x.en = en;
        sbq.push_back(x);
    endtask

    task automatic check_sb();
        exp_t x;
        @(negedge clk);
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue want entry");
        end else begin
            checks--;
            x = sbq.pop_front();
            chk("pkt_cnt",  64'(pkt_cnt),  64'(x.pkt));
            chk("err_cnt",  64'(err_cnt),  64'(x.ecnt));
            chk("err_flag", 64'(err_flag), 64'(x.flag));
            chk("err_en",   64'(err_en),   64'(x.en));
        end
    endtask

    initial begin
        //             tag     h1x h2x len nw last dbad clr  pkt err flg en
        vt[0]  = mk(64'h10, 0, 0,  4, 4,  3, -1, 0,   1, 0, 0, 0);
        vt[1]  = mk(64'h11, 0, 0,  4, 4,  3, -1, 0,   2, 0, 0, 0);
        vt[2]  = mk(64'h12, 0, 0,  4, 4,  3, -1, 0,   3, 0, 0, 0);
        vt[3]  = mk(64'h13, 1, 0,  4, 4,  3, -1, 0,   4, 1, 1, 1);
        vt[4]  = mk(64'h14, 0, 0,  4, 4,  3,  2, 0,   5, 2, 1, 1);
        vt[5]  = mk(64'h20, 0, 0,  4, 4,  3, -1, 1,   6, 1, 1, 0);
        vt[6]  = mk(64'h21, 0, 0,  4, 4,  3, -1, 0,   7, 1, 1, 0);
        vt[7]  = mk(64'h22, 0, 0,  4, 2,  1, -1, 0,   8, 2, 1, 0);
        vt[8]  = mk(64'h23, 0, 0,  4, 4, -1, -1, 0,   9, 3, 1, 0);
        vt[9]  = mk(64'h24, 0, 0,  4, 4,  3, -1, 0,  10, 3, 1, 0);
        vt[10] = mk(64'h25, 0, 2,  4, 4,  3, -1, 2,  11, 1, 1, 2);
        vt[11] = mk(64'h26, 0, 0, 20, 8,  7, -1, 0,  12, 1, 1, 2);

        evt_start = 64'h10; hdr1_ref = H1; hdr2_ref = H2; data_len = 16'd4;
        sif.data_in = '0; sif.data_valid = 1'b0; sif.data_last = 1'b0;

        #12;
        chk("rst pkt_cnt",  64'(pkt_cnt),  64'd0);
        chk("rst err_cnt",  64'(err_cnt),  64'd0);
        chk("rst err_flag", 64'(err_flag), 64'd0);
        chk("rst err_en",   64'(err_en),   64'd0);
        chk("rst captures", evt_expc | evt_seen | hdr1_expc | hdr1_seen |
                            hdr2_expc | hdr2_seen | data_expc | data_seen, 64'd0);

        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_en = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            if (vt[i].clr == 1) begin
                err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
            end
            push(vt[i].pkt, vt[i].ecnt, vt[i].flag, vt[i].en);
            send_pkt(vt[i]);
            check_sb();
            case (i)
                3: begin
                    chk("hdr1_expc", hdr1_expc, H1);
                    chk("hdr1_seen", hdr1_seen, H1 ^ 64'd1);
                end
                4: begin
                    chk("data_expc k2", data_expc, 64'h0000_0014_0000_0002);
                    chk("data_seen k2", data_seen, 64'h0000_0014_0000_0003);
                end
                5: begin
                    chk("evt_expc", evt_expc, 64'h15);
                    chk("evt_seen", evt_seen, 64'h20);
                end
                7: begin
                    chk("data_expc early", data_expc, 64'h0000_0022_0000_0001);
                    chk("data_seen early", data_seen, 64'h0000_0022_0000_0001);
                end
                10: begin
                    chk("hdr2_expc", hdr2_expc, H2);
                    chk("hdr2_seen", hdr2_seen, H2 ^ 64'd2);
                    chk("hdr1 cleared", hdr1_seen, 64'd0);
                end
                default: ;
            endcase
        end

        // check_en dropped mid-packet: partial packet discarded, errors kept
        data_len = 16'd4;
        send(64'h27, 1'b0, 1'b0);
        send(H1, 1'b0, 1'b0);
        check_en = 1'b0;
        @(posedge clk); #1;
        evt_start = 64'h40;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort pkt_cnt", 64'(pkt_cnt), 64'd12);
        chk("abort err_cnt", 64'(err_cnt), 64'd1);
        check_en = 1'b1;
        @(posedge clk); #1;
        push(13, 1, 1, 2);
        send_pkt(mk(64'h40, 0, 0, 4, 4, 3, -1, 0, 0, 0, 0, 0));
        check_sb();

        // asynchronous reset in the middle of DATA
        data_len = 16'd4;
        send(64'h41, 1'b0, 1'b0);
        send(H1, 1'b0, 1'b0);
        send(H2, 1'b0, 1'b0);
        send(64'h0000_0041_0000_0000, 1'b0, 1'b0);
        #2 reset_n = 1'b0; check_en = 1'b0;
        #1;
        chk("arst pkt_cnt",  64'(pkt_cnt),  64'd0);
        chk("arst err_cnt",  64'(err_cnt),  64'd0);
        chk("arst err_flag", 64'(err_flag), 64'd0);
        chk("arst captures", evt_expc | evt_seen | hdr1_expc | hdr1_seen |
                             hdr2_expc | hdr2_seen | data_expc | data_seen, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1; evt_start = 64'h50;
        for (int j = 0; j < 3; j++) send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("idle err_cnt", 64'(err_cnt), 64'd0);
        chk("idle pkt_cnt", 64'(pkt_cnt), 64'd0);
        check_en = 1'b1;
        @(posedge clk); #1;
        push(1, 0, 0, 0);
        send_pkt(mk(64'h50, 0, 0, 4, 4, 3, -1, 0, 0, 0, 0, 0));
        check_sb();

        // every word wrong for 70000 cycles
        sif.data_in = 64'hDEAD_BEEF_0BAD_F00D; sif.data_last = 1'b0; sif.data_valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1 sif.data_valid = 1'b0;
        @(negedge clk);
        chk("sat err_cnt",  64'(err_cnt),  64'hFFFF);
        chk("sat err_flag", 64'(err_flag), 64'd1);
        chk("sat err_en",   64'(err_en),   64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
